riscv_register_file_mp: RTL and testbench
=========================================

Name: riscv_register_file_mp

Overview:
- Parametrised RV32I/RV32E integer register file: NRD combinational read ports, one synchronous write port.
- Adds a per-register pending-write scoreboard, a sequential zeroing state machine (after reset and on request) and optional write-to-read bypass.
- Sits between decode (reads, scoreboard set) and writeback (write, scoreboard clear) in the core pipeline.

Parameters:
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; 32 (RV32I) or 16 (RV32E).
- NRD, 2, number of read ports; legal range 1..4.

Ports:
- i_clk  in  1  clock, rising edge active.
- i_rstn  in  1  asynchronous active-low reset.
- i_clr  in  1  request a full register clear; sampled in READY only.
- o_ready  out  1  1 = READY state; 0 = clearing.
- i_rd_wen  in  1  write enable.
- i_rd_addr  in  5  write address.
- i_rd_data  in  XLEN  write data.
- i_rs_addr  in  5*NRD  read addresses; port k = bits [5k+4:5k].
- o_rs_data  out  XLEN*NRD  read data; port k = bits [XLEN*k+XLEN-1:XLEN*k].
- i_sb_set  in  1  mark i_sb_addr as pending write.
- i_sb_addr  in  5  scoreboard set address.
- o_rs_busy  out  NRD  pending-write flag for each read address.

Behaviour:
- States: CLEAR, READY. Reset (i_rstn=0, asynchronous) forces CLEAR, clear counter=1, busy bits=0, o_ready=0. Register contents are not reset directly; CLEAR zeroes them.
- CLEAR: writes 0 to register[cnt] each cycle, cnt from 1 to NREG-1. In the cycle cnt==NREG-1, the state goes to READY. o_ready rises NREG-1 cycles after reset release (31 for NREG=32).
- During CLEAR:
  - i_rd_wen, i_sb_set and i_clr are ignored.
  - o_rs_data = 0 on all ports; o_rs_busy = 0.
- READY with i_clr=1: go to CLEAR next cycle, cnt=1, all busy bits cleared. A write in the same cycle still commits, but is then overwritten by the clear.
- Reset mid-CLEAR: restarts from cnt=1.
- Read: combinational, o_rs_data[k] = register[i_rs_addr[k]].
  - Address 0 always reads 0.
  - Address >= NREG reads 0 (RV32E).
- Write: at rising edge when i_rd_wen=1, READY, i_rd_addr != 0 and i_rd_addr < NREG. Otherwise the write is discarded.
- Scoreboard: busy[a] is set at the edge when i_sb_set=1, a=i_sb_addr, a != 0, a < NREG.
  - busy[a] is cleared at the edge of any accepted write to a.
  - Set and write to the same address in the same cycle: set wins (busy stays 1).
- o_rs_busy[k] = busy[i_rs_addr[k]]; 0 for address 0 or out of range.
- Multiple read ports may use the same address; each returns the same value independently.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined: for an accepted write this cycle (READY, wen=1, addr != 0, in range), any read port with i_rs_addr[k]==i_rd_addr returns i_rd_data combinationally, and o_rs_busy[k]=0 for that port unless i_sb_set targets the same address in the same cycle.
- Not defined: reads return the pre-write value until the following cycle; busy clears at the edge.

Test Plan:
- Reset release: o_ready stays 0 for 31 cycles (NREG=32), then 1; every register reads 0. A write of 0xDEADBEEF to x5 during CLEAR is not stored.
- Write loop: write x[i]=i for i=0..31, then read pairs (i, 31-i). x0 reads 0; others read the written value; NRD=3 third port matches.
- NREG=16: write x20=0x1234; reading x20 gives 0, and x15 keeps its earlier value.
- Scoreboard: sb_set x7, then o_rs_busy=1 on a port reading x7. Write x7=0x55: busy drops the next cycle (0 in the same cycle with RF_BYPASS_EN). Simultaneous sb_set x7 and write x7: busy stays 1.
- Bypass: write x3=0xA5A5A5A5 while reading x3. With RF_BYPASS_EN, 0xA5A5A5A5 in the same cycle; without, the old value that cycle, then 0xA5A5A5A5 the next.
- i_clr pulse in READY: o_ready drops for 31 cycles, all registers and busy bits read 0 afterwards. Reset asserted mid-clear restarts the full 31-cycle count.

Source files
------------

// File: rtl/riscv_register_file_mp.sv
// RV32I/RV32E integer register file: NRD combinational read ports, one write port,
// pending-write scoreboard and sequential zeroing. Define RF_BYPASS_EN for write-to-read bypass.
module riscv_register_file_mp #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int NRD  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_clr,
    output logic                 o_ready,
    input  logic                 i_rd_wen,
    input  logic [4:0]           i_rd_addr,
    input  logic [XLEN-1:0]      i_rd_data,
    input  logic [5*NRD-1:0]     i_rs_addr,
    output logic [XLEN*NRD-1:0]  o_rs_data,
    input  logic                 i_sb_set,
    input  logic [4:0]           i_sb_addr,
    output logic [NRD-1:0]       o_rs_busy
);

    localparam int AW = $clog2(NREG);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state_reg;
    logic [AW-1:0]   cnt_reg;
    logic [NREG-1:0] busy_reg;
    logic [XLEN-1:0] regs [NREG];

    logic            ready;
    logic            wr_ok;
    logic            sb_ok;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   sb_idx;

    // x0 and addresses beyond the implemented file (RV32E) are never stored or tracked
    function automatic logic in_range(input logic [4:0] a);
        return (a != 5'd0) && (int'(a) < NREG);
    endfunction

    assign ready   = (state_reg == READY);
    assign o_ready = ready;
    assign wr_ok   = ready && i_rd_wen && in_range(i_rd_addr);
    assign sb_ok   = ready && i_sb_set && in_range(i_sb_addr);
    assign wr_idx  = i_rd_addr[AW-1:0];
    assign sb_idx  = i_sb_addr[AW-1:0];

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= CLEAR;
            cnt_reg   <= AW'(1);
            busy_reg  <= '0;
        end else begin
            case (state_reg)
                CLEAR: begin
                    cnt_reg <= cnt_reg + AW'(1);
                    if (cnt_reg == AW'(NREG - 1))
                        state_reg <= READY;
                end
                READY: begin
                    if (i_clr) begin
                        state_reg <= CLEAR;
                        cnt_reg   <= AW'(1);
                        busy_reg  <= '0;
                    end else begin
                        // set is applied last so it wins over a same-cycle clear
                        if (wr_ok)
                            busy_reg[wr_idx] <= 1'b0;
                        if (sb_ok)
                            busy_reg[sb_idx] <= 1'b1;
                    end
                end
                default: state_reg <= CLEAR;
            endcase
        end
    end

    // Storage has no reset; the CLEAR sweep provides the zero contents
    always_ff @(posedge i_clk) begin
        if (state_reg == CLEAR)
            regs[cnt_reg] <= '0;
        else if (wr_ok)
            regs[wr_idx] <= i_rd_data;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NRD; gi++) begin : g_rd
            logic [4:0]      ra;
            logic [XLEN-1:0] data;
            logic            busy;

            assign ra = i_rs_addr[5*gi +: 5];

            always_comb begin
                data = '0;
                busy = 1'b0;
                if (ready && in_range(ra)) begin
                    data = regs[ra[AW-1:0]];
                    busy = busy_reg[ra[AW-1:0]];
`ifdef RF_BYPASS_EN
                    if (wr_ok && (ra == i_rd_addr)) begin
                        data = i_rd_data;
                        busy = sb_ok && (i_sb_addr == ra);
                    end
`endif
                end
            end

            assign o_rs_data[XLEN*gi +: XLEN] = data;
            assign o_rs_busy[gi]              = busy;
        end
    endgenerate

endmodule

// File: tb/tb_riscv_register_file_mp.sv
// Directed self-checking bench for riscv_register_file_mp: an RV32I instance with three
// read ports and an RV32E instance with two. Expectations follow RF_BYPASS_EN when defined.
module tb_riscv_register_file_mp;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn;
    logic        clr, wen, sb_set, ready;
    logic [4:0]  wa, sb_addr;
    logic [31:0] wd;
    logic [14:0] ra;
    logic [95:0] rd;
    logic [2:0]  busy;

    logic        e_clr, e_wen, e_sb_set, e_ready;
    logic [4:0]  e_wa, e_sb_addr;
    logic [31:0] e_wd;
    logic [9:0]  e_ra;
    logic [63:0] e_rd;
    logic [1:0]  e_busy;

    riscv_register_file_mp #(.XLEN(32), .NREG(32), .NRD(3)) dut (
        .i_clk(clk), .i_rstn(rstn), .i_clr(clr), .o_ready(ready),
        .i_rd_wen(wen), .i_rd_addr(wa), .i_rd_data(wd),
        .i_rs_addr(ra), .o_rs_data(rd),
        .i_sb_set(sb_set), .i_sb_addr(sb_addr), .o_rs_busy(busy)
    );

    riscv_register_file_mp #(.XLEN(32), .NREG(16), .NRD(2)) dut_e (
        .i_clk(clk), .i_rstn(rstn), .i_clr(e_clr), .o_ready(e_ready),
        .i_rd_wen(e_wen), .i_rd_addr(e_wa), .i_rd_data(e_wd),
        .i_rs_addr(e_ra), .o_rs_data(e_rd),
        .i_sb_set(e_sb_set), .i_sb_addr(e_sb_addr), .o_rs_busy(e_busy)
    );

    typedef struct {
        logic [4:0]  ra0, ra1, ra2;
        logic [31:0] e0, e1, e2;
    } rd_vec_t;

    rd_vec_t vecs [32];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] port(input int k);
        return rd[32*k +: 32];
    endfunction

    // Counts edges until ready rises, bounded so a stuck design still reaches the summary
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
        end
        check(name, 32'(n), 32'd31);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 32; i++) begin
            ra = {5'(i), 5'(i), 5'(i)};
            #1;
            check($sformatf("%s_data_x%0d", tag, i), port(0), 32'd0);
            check($sformatf("%s_busy_x%0d", tag, i), 32'(busy[0]), 32'd0);
        end
    endtask

    initial begin
        int n, ne;

        rstn = 1'b0; clr = 0; wen = 0; sb_set = 0; wa = 0; sb_addr = 0; wd = 0; ra = 0;
        e_clr = 0; e_wen = 0; e_sb_set = 0; e_wa = 0; e_sb_addr = 0; e_wd = 0; e_ra = 0;
        repeat (3) tick();
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Release reset while hammering a write to x5 and a scoreboard set on x6
        rstn = 1'b1;
        wen = 1; wa = 5'd5; wd = 32'hDEADBEEF;
        sb_set = 1; sb_addr = 5'd6;
        ra = {5'd6, 5'd5, 5'd5};
        #1;
        check("clear_rd_x5", port(0), 32'd0);
        n = 0; ne = 0;
        while (!ready && n < 200) begin
            tick();
            n++;
            if (e_ready && ne == 0) ne = n;
        end
        wen = 0; sb_set = 0;
        check("rst_ready_cycles", 32'(n), 32'd31);
        check("rv32e_ready_cycles", 32'(ne), 32'd15);
        ra = {5'd6, 5'd5, 5'd5};
        #1;
        check("x5_not_written", port(0), 32'd0);
        check("x6_not_busy", 32'(busy[2]), 32'd0);
        check_all_zero("post_rst");

        // Fill x[i] = i, then read pairs through the table
        for (int i = 0; i < 32; i++) begin
            wen = 1; wa = 5'(i); wd = 32'(i);
            tick();
        end
        wen = 0;
        for (int i = 0; i < 32; i++) begin
            vecs[i].ra0 = 5'(i);
            vecs[i].ra1 = 5'(31 - i);
            vecs[i].ra2 = 5'((i * 7) % 32);
            vecs[i].e0  = 32'(i);
            vecs[i].e1  = 32'(31 - i);
            vecs[i].e2  = 32'((i * 7) % 32);
        end
        for (int v = 0; v < 32; v++) begin
            ra = {vecs[v].ra2, vecs[v].ra1, vecs[v].ra0};
            #1;
            $display("vec %0d: rs=(%0d,%0d,%0d) data=(%h,%h,%h)", v,
                     vecs[v].ra0, vecs[v].ra1, vecs[v].ra2, port(0), port(1), port(2));
            check($sformatf("vec%0d_p0", v), port(0), vecs[v].e0);
            check($sformatf("vec%0d_p1", v), port(1), vecs[v].e1);
            check($sformatf("vec%0d_p2", v), port(2), vecs[v].e2);
        end

        // RV32E: x20 is outside the file, x15 is the top register
        e_wen = 1; e_wa = 5'd15; e_wd = 32'h00000F15;
        tick();
        e_wa = 5'd20; e_wd = 32'h00001234;
        tick();
        e_wen = 0;
        e_sb_set = 1; e_sb_addr = 5'd20;
        tick();
        e_sb_addr = 5'd15;
        tick();
        e_sb_set = 0;
        e_ra = {5'd15, 5'd20};
        #1;
        check("e_x20_data", e_rd[31:0], 32'd0);
        check("e_x15_data", e_rd[63:32], 32'h00000F15);
        check("e_x20_busy", 32'(e_busy[0]), 32'd0);
        check("e_x15_busy", 32'(e_busy[1]), 32'd1);

        // Scoreboard set, clear by write, and same-cycle set+write
        sb_set = 1; sb_addr = 5'd7;
        tick();
        sb_set = 0;
        ra = {5'd0, 5'd7, 5'd0};
        #1;
        check("sb_x7_busy", 32'(busy[1]), 32'd1);
        check("sb_x0_busy", 32'(busy[0]), 32'd0);
        wen = 1; wa = 5'd7; wd = 32'h55;
        #1;
`ifdef RF_BYPASS_EN
        check("sb_wr_same_busy", 32'(busy[1]), 32'd0);
        check("sb_wr_same_data", port(1), 32'h55);
`else
        check("sb_wr_same_busy", 32'(busy[1]), 32'd1);
        check("sb_wr_same_data", port(1), 32'd7);
`endif
        tick();
        wen = 0;
        check("sb_wr_next_busy", 32'(busy[1]), 32'd0);
        check("sb_wr_next_data", port(1), 32'h55);
        sb_set = 1; sb_addr = 5'd7; wen = 1; wa = 5'd7; wd = 32'h66;
        tick();
        sb_set = 0; wen = 0;
        check("sb_set_wins_busy", 32'(busy[1]), 32'd1);
        check("sb_set_wins_data", port(1), 32'h66);
        wen = 1; wa = 5'd7; wd = 32'h77;
        tick();
        wen = 0;
        check("sb_clear_again", 32'(busy[1]), 32'd0);

        // Write-to-read on x3
        ra = {5'd3, 5'd0, 5'd0};
        wen = 1; wa = 5'd3; wd = 32'hA5A5A5A5;
        #1;
`ifdef RF_BYPASS_EN
        check("byp_same", port(2), 32'hA5A5A5A5);
`else
        check("byp_same", port(2), 32'd3);
`endif
        tick();
        wen = 0;
        check("byp_next", port(2), 32'hA5A5A5A5);

        // Clear request with a concurrent write and a pending busy bit on x9
        sb_set = 1; sb_addr = 5'd9;
        tick();
        sb_set = 0;
        ra = {5'd9, 5'd10, 5'd9};
        #1;
        check("pre_clr_busy_x9", 32'(busy[0]), 32'd1);
        clr = 1; wen = 1; wa = 5'd10; wd = 32'h00000BAD;
        tick();
        clr = 0; wen = 0;
        check("clr_ready_low", 32'(ready), 32'd0);
        check("clr_rd_zero", port(1), 32'd0);
        wait_ready("clr_ready_cycles");
        check_all_zero("post_clr");

        // Reset in the middle of a clear restarts the full sweep
        clr = 1;
        tick();
        clr = 0;
        repeat (10) tick();
        check("midclr_ready_low", 32'(ready), 32'd0);
        rstn = 1'b0;
        #2;
        check("midclr_rst_ready", 32'(ready), 32'd0);
        tick();
        rstn = 1'b1;
        wait_ready("midclr_rst_cycles");
        ra = {5'd3, 5'd3, 5'd3};
        #1;
        check("after_rst_x3", port(0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
